// File: rtl/i2c_master_ctrl_pkg.sv
// Shared constants for the single-byte I2C master: bus widths, command/status
// field positions and FSM state encodings.
package i2c_master_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 7;

  localparam int CMD_RW_BIT   = 15;
  localparam int CMD_ADDR_MSB = 14;
  localparam int CMD_ADDR_LSB = 8;

  localparam int ST_READY_BIT   = DATA_WIDTH;
  localparam int ST_ACK_ERR_BIT = 8;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_WDATA    = 4'd4;
  localparam logic [3:0] S_WACK     = 4'd5;
  localparam logic [3:0] S_RDATA    = 4'd6;
  localparam logic [3:0] S_MNACK    = 4'd7;
  localparam logic [3:0] S_STOP     = 4'd8;

  function automatic logic [DATA_WIDTH:0] pack_status(input logic ready,
                                                      input logic ack_err,
                                                      input logic [7:0] rdata);
    logic [DATA_WIDTH:0] s;
    s                 = '0;
    s[ST_READY_BIT]   = ready;
    s[ST_ACK_ERR_BIT] = ack_err;
    s[7:0]            = rdata;
    return s;
  endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Command/status and I2C pin bundle between the register block and the master.
interface i2c_master_ctrl_if;

  logic [i2c_master_ctrl_pkg::DATA_WIDTH-1:0] cmd_word;
  logic                                       cmd_valid;
  logic [i2c_master_ctrl_pkg::DATA_WIDTH:0]   i2c_status;
  logic                                       done;
  logic                                       scl_o;
  logic                                       sda_oe;
  logic                                       sda_i;

  modport master (input cmd_word, cmd_valid, sda_i,
                  output i2c_status, done, scl_o, sda_oe);
  modport slave  (output cmd_word, cmd_valid, sda_i,
                  input i2c_status, done, scl_o, sda_oe);

endinterface

// File: rtl/i2c_clk_div.sv
// Quarter-period tick generator: counts 0..CLK_DIV-1 while enabled, held at 0 otherwise.
module i2c_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, one data byte, STOP, driven from
// an APB command word; every bit slot is four quarter ticks long.
module i2c_master_ctrl
  import i2c_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic               clk,
  input logic               reset,
  i2c_master_ctrl_if.master bus
);

  logic [3:0] state;
  logic [1:0] quarter;
  logic [2:0] bit_cnt;
  logic [7:0] tx;
  logic [7:0] rx;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rw;
  logic       ack_err;
  logic       done;
  logic       tick;
  logic       div_en;
  logic       scl;
  logic       sda_oe;
  logic       unused_cmd_bits;

  assign unused_cmd_bits = ^bus.cmd_word[DATA_WIDTH-1:CMD_RW_BIT+1];
  assign div_en          = (state != S_IDLE);

  i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rst  (reset),
    .en   (div_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      quarter <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      wdata   <= '0;
      rdata   <= '0;
      rw      <= 1'b0;
      ack_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        quarter <= '0;
        bit_cnt <= '0;
        if (bus.cmd_valid) begin
          rw      <= bus.cmd_word[CMD_RW_BIT];
          wdata   <= bus.cmd_word[7:0];
          tx      <= {bus.cmd_word[CMD_ADDR_MSB:CMD_ADDR_LSB], bus.cmd_word[CMD_RW_BIT]};
          ack_err <= 1'b0;
          state   <= S_START;
        end
      end else if (tick) begin
        quarter <= quarter + 2'd1;
        // SDA is sampled in the middle of the SCL high phase
        if (quarter == 2'd1) begin
          case (state)
            S_ADDR_ACK, S_WACK: if (bus.sda_i) ack_err <= 1'b1;
            S_RDATA:            rx <= {rx[6:0], bus.sda_i};
            default:            ;
          endcase
        end
        if (quarter == 2'd3) begin
          case (state)
            S_START: state <= S_ADDR;
            S_ADDR, S_WDATA: begin
              tx      <= {tx[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= (state == S_ADDR) ? S_ADDR_ACK : S_WACK;
            end
            S_ADDR_ACK: begin
              tx <= wdata;
              if (ack_err) state <= S_STOP;
              else         state <= rw ? S_RDATA : S_WDATA;
            end
            S_WACK: state <= S_STOP;
            S_RDATA: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rdata <= rx;
                state <= S_MNACK;
              end
            end
            S_MNACK: state <= S_STOP;
            S_STOP: begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Pin levels follow directly from state and quarter so reset idles the bus at once
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state)
      S_START: begin
        scl    = (quarter != 2'd3);
        sda_oe = (quarter != 2'd0);
      end
      S_STOP: begin
        scl    = (quarter != 2'd0);
        sda_oe = (quarter < 2'd2);
      end
      S_ADDR, S_WDATA: begin
        scl    = quarter[0] ^ quarter[1];
        sda_oe = ~tx[7];
      end
      S_ADDR_ACK, S_WACK, S_RDATA, S_MNACK: begin
        scl = quarter[0] ^ quarter[1];
      end
      default: ;
    endcase
  end

  assign bus.scl_o      = scl;
  assign bus.sda_oe     = sda_oe;
  assign bus.done       = done;
  assign bus.i2c_status = pack_status(state == S_IDLE, ack_err, rdata);

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a bus-level slave/monitor decodes START, bytes, ACKs
// and STOP from the pins; expectations come from the command fields and slave setup.
module tb_i2c_master_ctrl;
  import i2c_master_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_master_ctrl_if bus2 ();
  i2c_master_ctrl_if bus1 ();

  i2c_master_ctrl #(.CLK_DIV(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  i2c_master_ctrl #(.CLK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  // slave model attaches to one instance at a time (sel1=1 -> CLK_DIV=1 instance)
  bit          sel1     = 1'b0;
  logic        pull     = 1'b0;
  bit          ack_addr = 1'b1;
  bit          ack_data = 1'b1;
  logic [7:0]  rbyte    = 8'h00;
  logic        scl_m, oe_m, line, done_m;
  logic [DATA_WIDTH:0] status_m;

  assign scl_m    = sel1 ? bus1.scl_o      : bus2.scl_o;
  assign oe_m     = sel1 ? bus1.sda_oe     : bus2.sda_oe;
  assign done_m   = sel1 ? bus1.done       : bus2.done;
  assign status_m = sel1 ? bus1.i2c_status : bus2.i2c_status;
  assign line     = ~(oe_m | pull);
  assign bus1.sda_i = line;
  assign bus2.sda_i = line;

  logic [7:0] model_rdata [2];

  bit         in_frame = 1'b0;
  int         bitn = 0, byten = 0, n_start = 0, n_stop = 0;
  logic [8:0] cur = '0;
  bit         slave_rw = 1'b0;
  logic [8:0] obs[$];
  logic       scl_q = 1'b1, line_q = 1'b1;
  int         hi_run = 0;
  int         runs[$];

  always @(scl_m or line) begin
    if (scl_m === 1'b1 && scl_q === 1'b1 && line_q === 1'b1 && line === 1'b0) begin
      n_start++; in_frame = 1'b1; bitn = 0; byten = 0; cur = '0;
    end else if (scl_m === 1'b1 && scl_q === 1'b1 && line_q === 1'b0 && line === 1'b1 && in_frame) begin
      n_stop++; in_frame = 1'b0;
    end else if (scl_q === 1'b0 && scl_m === 1'b1 && in_frame) begin
      cur = {cur[7:0], line};
      bitn++;
      if (bitn == 9) begin
        obs.push_back(cur);
        if (byten == 0) slave_rw = cur[1];
        bitn = 0;
        byten++;
      end
    end else if (scl_q === 1'b1 && scl_m === 1'b0 && in_frame) begin
      if (bitn == 8) begin
        if (byten == 0)     pull = ack_addr;
        else if (!slave_rw) pull = ack_data;
        else                pull = 1'b0;
      end else if (byten == 1 && slave_rw && ack_addr) begin
        pull = ~rbyte[7-bitn];
      end else begin
        pull = 1'b0;
      end
    end
    scl_q  = scl_m;
    line_q = line;
  end

  always @(negedge clk) begin
    if (scl_m === 1'b1) hi_run++;
    else if (hi_run > 0) begin
      runs.push_back(hi_run);
      hi_run = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_model();
    obs.delete(); runs.delete();
    hi_run = 0; n_start = 0; n_stop = 0; in_frame = 1'b0;
    bitn = 0; byten = 0; cur = '0; pull = 1'b0;
  endtask

  task automatic drive(input bit use1, input logic [31:0] w, input logic v);
    if (use1) begin bus1.cmd_word = w; bus1.cmd_valid = v; end
    else      begin bus2.cmd_word = w; bus2.cmd_valid = v; end
  endtask

  task automatic run_txn(input string name, input bit use1, input logic [31:0] word,
                         input bit a_ack, input bit d_ack, input logic [7:0] rb,
                         input logic [31:0] word2, input int second_at);
    int div, cyc, first_done, n_done, exp_lat, exp_slots, limit;
    bit rw, exp_err;
    logic [6:0] addr;
    logic [7:0] wd;
    logic [8:0] exp_q[$];
    logic [DATA_WIDTH:0] exp_status;
    div  = use1 ? 1 : 2;
    rw   = word[15];
    addr = word[14:8];
    wd   = word[7:0];
    exp_q.push_back({addr, rw, ~a_ack});
    if (a_ack) exp_q.push_back(rw ? {rb, 1'b1} : {wd, ~d_ack});
    exp_err = !a_ack || (!rw && !d_ack);
    if (a_ack && rw) model_rdata[use1] = rb;
    exp_slots  = a_ack ? 18 : 9;
    exp_lat    = (4 + 4 * exp_slots + 4) * div + 1;
    exp_status = {1'b1, 23'd0, exp_err, model_rdata[use1]};

    @(negedge clk);
    clear_model();
    sel1 = use1; ack_addr = a_ack; ack_data = d_ack; rbyte = rb;
    drive(use1, word, 1'b1);
    cyc = 0; first_done = -1; n_done = 0; limit = exp_lat + 40;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        drive(use1, word, 1'b0);
        n_checks++;
        if (status_m[DATA_WIDTH] !== 1'b0) begin
          n_fail++;
          $display("FAIL %s ready_while_busy: got %b expected 0", name, status_m[DATA_WIDTH]);
        end
      end
      if (second_at != 0 && cyc == second_at)     drive(use1, word2, 1'b1);
      if (second_at != 0 && cyc == second_at + 1) drive(use1, word2, 1'b0);
      if (done_m === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
      end
    end

    n_checks++;
    if (first_done != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, first_done, exp_lat);
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, n_done);
    end
    n_checks++;
    if (status_m !== exp_status) begin
      n_fail++;
      $display("FAIL %s status: got %h expected %h", name, status_m, exp_status);
    end
    n_checks++;
    if (n_start != 1 || n_stop != 1) begin
      n_fail++;
      $display("FAIL %s start_stop: got %0d/%0d expected 1/1", name, n_start, n_stop);
    end
    n_checks++;
    if (obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s byte_count: got %0d expected %0d", name, obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s byte%0d {data,ack}: got %h expected %h", name, i, obs[i], exp_q[i]);
      end
    end
    n_checks++;
    if (runs.size() != exp_slots + 1) begin
      n_fail++;
      $display("FAIL %s scl_pulses: got %0d expected %0d", name, runs.size() - 1, exp_slots);
    end
    for (int i = 1; i < runs.size(); i++) begin
      n_checks++;
      if (runs[i] != 2 * div) begin
        n_fail++;
        $display("FAIL %s scl_high%0d: got %0d expected %0d", name, i, runs[i], 2 * div);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus2.i2c_status !== {1'b1, 32'd0} || bus1.i2c_status !== {1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_status: got %h/%h expected %h", bus2.i2c_status, bus1.i2c_status, {1'b1, 32'd0});
    end
    n_checks++;
    if (bus2.scl_o !== 1'b1 || bus1.scl_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_scl: got %b/%b expected 1/1", bus2.scl_o, bus1.scl_o);
    end
    n_checks++;
    if (bus2.sda_oe !== 1'b0 || bus1.sda_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sda_oe: got %b/%b expected 0/0", bus2.sda_oe, bus1.sda_oe);
    end
    n_checks++;
    if (bus2.done !== 1'b0 || bus1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b/%b expected 0/0", bus2.done, bus1.done);
    end
    model_rdata[0] = 8'h00;
    model_rdata[1] = 8'h00;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    run_txn("write", 1'b0, 32'h0000_50A5, 1'b1, 1'b1, 8'h00, 32'h0, 0);
  endtask

  task automatic test_read();
    run_txn("read", 1'b0, 32'h0000_D100, 1'b1, 1'b1, 8'h3C, 32'h0, 0);
  endtask

  task automatic test_addr_nack();
    run_txn("addr_nack", 1'b0, 32'h0000_50A5, 1'b0, 1'b1, 8'h00, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    run_txn("busy_reject", 1'b0, 32'h0000_50A5, 1'b1, 1'b1, 8'h00, 32'h0000_9234, 10);
  endtask

  task automatic test_async_reset();
    int waited;
    bit hit;
    @(negedge clk);
    clear_model();
    sel1 = 1'b0; ack_addr = 1'b1; ack_data = 1'b1;
    drive(1'b0, 32'h0000_50A5, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0000_50A5, 1'b0);
    hit = 1'b0;
    waited = 0;
    while (!hit && waited < 200) begin
      @(negedge clk);
      waited++;
      if (waited > 12 && bus2.scl_o === 1'b0 && bus2.sda_oe === 1'b1) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL async_reset_setup: got no low-SCL driven-SDA point within %0d cycles", waited);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (bus2.scl_o !== 1'b1 || bus2.sda_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_pins: got scl=%b sda_oe=%b expected scl=1 sda_oe=0", bus2.scl_o, bus2.sda_oe);
    end
    n_checks++;
    if (bus2.i2c_status !== {1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL async_reset_status: got %h expected %h", bus2.i2c_status, {1'b1, 32'd0});
    end
    model_rdata[0] = 8'h00;
    model_rdata[1] = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_txn("after_reset", 1'b0, 32'h0000_2B5A, 1'b1, 1'b1, 8'h00, 32'h0, 0);
  endtask

  task automatic test_clk_div1();
    run_txn("div1_write", 1'b1, 32'h0000_50A5, 1'b1, 1'b1, 8'h00, 32'h0, 0);
    run_txn("div1_read", 1'b1, 32'h0000_C700, 1'b1, 1'b1, 8'h96, 32'h0, 0);
  endtask

  task automatic test_random();
    bit use1, a_ack, d_ack;
    logic [31:0] word;
    logic [7:0] rb;
    for (int k = 0; k < 8; k++) begin
      use1  = 1'($urandom_range(0, 1));
      word  = $urandom;
      a_ack = ($urandom_range(0, 3) != 0);
      d_ack = ($urandom_range(0, 3) != 0);
      rb    = 8'($urandom);
      run_txn($sformatf("rand%0d", k), use1, word, a_ack, d_ack, rb, 32'h0, 0);
    end
  endtask

  initial begin
    bus1.cmd_word = '0; bus1.cmd_valid = 1'b0;
    bus2.cmd_word = '0; bus2.cmd_valid = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_back_to_back();
    test_async_reset();
    test_clk_div1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-byte I2C master sequencer behind the APB peripheral register.
- Takes a command word written through APB (`perdata`) and runs one complete bus transaction: START, 7-bit address + R/W, one data byte, STOP.
- Returns a status word in the `dataWidth`+1 format the APB block reads back: the ready bit is the MSB.

Parameters:
- CLK_DIV, 4, clk cycles per SCL quarter-period (minimum 1); one SCL bit = 4*CLK_DIV cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_word  in  `dataWidth  command fields:
  - [7:0] write data
  - [14:8] 7-bit slave address
  - [15] rw (1 = read)
  - upper bits ignored.
- cmd_valid  in  1  one-cycle strobe; accepted only when idle.
- i2c_status  out  `dataWidth+1  status word:
  - [`dataWidth] ready (=~busy)
  - [8] ack_err
  - [7:0] rdata
  - all other bits 0.
- done  out  1  one-cycle pulse when a transaction finishes (including aborted ones).
- scl_o  out  1  SCL level, push-pull; no clock stretching supported.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- sda_i  in  1  sampled SDA line (already synchronised externally).

Behaviour:
- Reset (async, immediate, also mid-transaction):
  - state IDLE, scl_o=1, sda_oe=0, done=0.
  - rdata=0, ack_err=0, ready=1; all counters 0.
- Quarter tick:
  - Divider counts 0..CLK_DIV-1 while not IDLE; tick when count = CLK_DIV-1.
  - All state/quarter advances occur on tick only.
- Bit slot = quarters q0..q3:
  - q0: SCL low, drive SDA.
  - q1, q2: SCL high.
  - q3: SCL low.
  - sda_i is sampled on the tick ending q1.
- FSM states: IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, MNACK, STOP.
- IDLE:
  - On cmd_valid: latch address, rw and wdata; clear ack_err; ready=0; go to START on the next clk.
  - cmd_valid while not IDLE is ignored, with no effect.
- START (4 quarters): SDA released, SCL high; sda_oe=1 at q1 (SDA falls while SCL is high); SCL low at q3.
- ADDR: 8 bit slots, MSB first, {addr[6:0], rw}. sda_oe = ~bit.
- ADDR_ACK: 1 slot with SDA released.
  - sda_i=1 (NACK) -> ack_err=1, go to STOP.
  - Otherwise go to WDATA (rw=0) or RDATA (rw=1).
- WDATA: 8 slots, MSB first. Then WACK: 1 slot released; sda_i=1 -> ack_err=1. Then STOP.
- RDATA: 8 slots released; shift sda_i in MSB first. At the end, rdata is updated with the full byte.
- MNACK: 1 slot with SDA released (master NACK, single-byte read). Then STOP.
- STOP (4 quarters):
  - q0: sda_oe=1, SCL low.
  - q1: SCL high.
  - q2: sda_oe=0 (SDA rises while SCL is high).
  - q3: idle levels.
- End of STOP: done=1 for one clk, ready=1, back to IDLE.
- Transaction latency, cmd_valid to done:
  - Full transaction: (4+36+36+4)*CLK_DIV + 1 cycles.
  - Address NACK: (4+36+4)*CLK_DIV + 1 cycles.
- rdata holds its last value across write transactions; it changes only at RDATA completion or reset.
- Bit counter: 3 bits, wraps 7->0 at the end of each byte field.

Decomposition:
- Shared include macros.vh carries:
  - `dataWidth and `addrWidth;
  - state encodings as `define constants;
  - command field positions: `CMD_RW_BIT = 15, `CMD_ADDR_MSB/LSB = 14/8;
  - status bit positions: ready = `dataWidth, ack_err = 8.
- One sub-module: i2c_clk_div. Counter + quarter tick; enable input, cleared when disabled.

Test Plan:
- Write transaction: CLK_DIV=2, cmd_word=0x0000_50A5 (addr 0x50, write 0xA5), slave model ACKs everything.
  - SDA sequence is START, 0xA0, ACK, 0xA5, ACK, STOP.
  - done occurs 161 cycles after cmd_valid; ack_err=0; ready=1.
- Read transaction: cmd_word=0x0000_D100 (rw=1, addr 0x51); slave returns 0x3C.
  - Address byte is 0xA3; master NACKs after the data byte.
  - i2c_status[7:0]=0x3C, [8]=0.
- Address NACK: slave does not ACK the address.
  - No data slots run; STOP follows directly.
  - done at 4*... = 89 cycles (CLK_DIV=2); ack_err=1.
- Busy rejection: second cmd_valid 10 cycles after the first.
  - Ignored; exactly one done pulse.
  - Bus bytes match the first command only.
- Async reset mid-ADDR: assert reset between clk edges.
  - scl_o=1 and sda_oe=0 immediately; ready=1.
  - After release, a new command completes normally.
- CLK_DIV=1 boundary: write transaction completes in 81 cycles.
  - SCL high time is exactly 2 cycles per bit.
